vga_sync_tracker: RTL and testbench

//  Receive-side counterpart of the VGA timing generator. Samples incoming

---
 rtl/vga_sync_tracker.sv | 86 ++++++++
 tb/tb_vga_sync_tracker.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/vga_sync_tracker.sv
// vga_sync_tracker: recovers pixel/line position from external sync and tracks lock
module vga_sync_tracker #(
  parameter int H_TOTAL     = 800,
  parameter int V_TOTAL     = 525,
  parameter int H_ACT_START = 144,
  parameter int H_ACTIVE    = 640,
  parameter int V_ACT_START = 35,
  parameter int V_ACTIVE    = 480,
  parameter int LOCK_LINES  = 4,
  parameter bit SYNC_POL    = 1'b0
) (
  input  logic       pixel_clk,
  input  logic       reset,
  input  logic       hsync_in,
  input  logic       vsync_in,
  output logic [9:0] h_pos,
  output logic [9:0] v_pos,
  output logic       active,
  output logic       locked,
  output logic       line_start,
  output logic       frame_start,
  output logic       sync_err
);
  localparam int CW = $clog2(LOCK_LINES + 1);
  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic hs_d, vs_d, first, frame_seen;
  logic hs_a, vs_a, hs_edge, vs_edge, match, timeout, frame_bad;
  assign hs_a = hsync_in == SYNC_POL;
  assign vs_a = vsync_in == SYNC_POL;
  assign hs_edge = hs_a && !hs_d;
  assign vs_edge = vs_a && !vs_d;
  assign match = hs_edge && first && ({1'b0, h_pos} + 11'd1 == 11'(H_TOTAL));
  assign timeout = !hs_edge && {1'b0, h_pos} == 11'(H_TOTAL);
  assign frame_bad = state == LOCKED && frame_seen && vs_edge && ({1'b0, v_pos} + 11'd1 != 11'(V_TOTAL));
  assign active = locked
    && {1'b0, h_pos} >= 11'(H_ACT_START) && {1'b0, h_pos} < 11'(H_ACT_START + H_ACTIVE)
    && {1'b0, v_pos} >= 11'(V_ACT_START) && {1'b0, v_pos} < 11'(V_ACT_START + V_ACTIVE);
  // lock decision on each line edge; timeout and bad frame length override it
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    if (hs_edge) begin
      if (!match) state_n = SEARCH;
      else if (state == SEARCH) begin
        state_n = VERIFY;
        cnt_n = CW'(1);
      end else if (state == VERIFY) begin
        cnt_n = cnt + 1'b1;
        state_n = cnt_n == CW'(LOCK_LINES) ? LOCKED : VERIFY;
      end
    end
    if (timeout || frame_bad) state_n = SEARCH;
  end
  // sync history, position counters, lock state and status pulses
  always_ff @(posedge pixel_clk) begin
    if (!reset) begin
      hs_d <= 1'b0;
      vs_d <= 1'b0;
      h_pos <= '0;
      v_pos <= '0;
      line_start <= 1'b0;
      frame_start <= 1'b0;
      first <= 1'b0;
      frame_seen <= 1'b0;
      state <= SEARCH;
      cnt <= '0;
      locked <= 1'b0;
      sync_err <= 1'b0;
    end else begin
      hs_d <= hs_a;
      vs_d <= vs_a;
      h_pos <= hs_edge ? '0 : &h_pos ? h_pos : h_pos + 1'b1;
      v_pos <= vs_edge ? '0 : hs_edge && !(&v_pos) ? v_pos + 1'b1 : v_pos;
      line_start <= hs_edge;
      frame_start <= vs_edge;
      first <= first | hs_edge;
      frame_seen <= state == LOCKED && state_n == LOCKED && (frame_seen | vs_edge);
      state <= state_n;
      cnt <= cnt_n;
      locked <= state_n == LOCKED;
      sync_err <= state == LOCKED && state_n != LOCKED;
    end
  end
endmodule

// File: tb/tb_vga_sync_tracker.sv
// tb_vga_sync_tracker: directed sync streams with hand-computed expectations
module tb_vga_sync_tracker;
  localparam int HT = 100;
  localparam int VT = 12;
  logic pixel_clk = 1'b0;
  logic reset, hsync_in, vsync_in;
  logic [9:0] h_pos, v_pos;
  logic active, locked, line_start, frame_start, sync_err;
  int checks = 0, errors = 0;
  int err_cnt = 0, long_err = 0;
  logic err_prev = 1'b0;
  logic cap = 1'b0;
  logic act_v3 [0:127];
  logic act_v2, act_v8, act_v9;
  logic f_lk, f_err, f_fs, f_ls;
  logic [9:0] f_vp, f_hp;

  vga_sync_tracker #(
    .H_TOTAL(HT), .V_TOTAL(VT), .H_ACT_START(20), .H_ACTIVE(60),
    .V_ACT_START(3), .V_ACTIVE(6), .LOCK_LINES(4), .SYNC_POL(1'b0)
  ) dut (
    .pixel_clk(pixel_clk), .reset(reset), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .h_pos(h_pos), .v_pos(v_pos), .active(active), .locked(locked),
    .line_start(line_start), .frame_start(frame_start), .sync_err(sync_err)
  );

  always #5 pixel_clk = ~pixel_clk;

  // sync_err pulse counting and active-window capture, sampled mid-cycle
  always @(negedge pixel_clk) begin
    if (sync_err) begin
      err_cnt++;
      if (err_prev) long_err++;
    end
    err_prev = sync_err;
    if (cap && v_pos == 10'd3) act_v3[h_pos[6:0]] = active;
    if (cap && v_pos == 10'd2 && h_pos == 10'd50) act_v2 = active;
    if (cap && v_pos == 10'd8 && h_pos == 10'd50) act_v8 = active;
    if (cap && v_pos == 10'd9 && h_pos == 10'd50) act_v9 = active;
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input logic hs, input logic vs);
    hsync_in = hs;
    vsync_in = vs;
    @(posedge pixel_clk);
    #1;
  endtask

  task automatic run_line(input int len, input bit vs_on);
    for (int i = 0; i < len; i++) begin
      step(i < 10 ? 1'b0 : 1'b1, vs_on ? 1'b0 : 1'b1);
      if (i == 0) begin
        f_lk = locked; f_err = sync_err; f_fs = frame_start;
        f_ls = line_start; f_vp = v_pos; f_hp = h_pos;
      end
    end
  endtask

  task automatic run_frame(input int lines);
    for (int l = 0; l < lines; l++) run_line(HT, l < 2);
  endtask

  initial begin
    reset = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
    check("rst_h_pos", h_pos, 0);
    check("rst_locked", locked, 0);
    check("rst_sync_err", sync_err, 0);
    reset = 1'b1;
    run_line(HT, 1);
    check("first_line_start", f_ls, 1);
    check("first_frame_start", f_fs, 1);
    check("first_h_pos", f_hp, 0);
    run_line(HT, 1);
    run_line(HT, 0);
    run_line(HT, 0);
    check("not_locked_edge4", locked, 0);
    run_line(HT, 0);
    check("locked_edge5", f_lk, 1);
    check("no_frame_start_mid", f_fs, 0);
    for (int l = 5; l < VT; l++) run_line(HT, 0);
    cap = 1'b1;
    run_frame(VT);
    cap = 1'b0;
    check("end_v_pos", v_pos, VT - 1);
    check("end_h_pos", h_pos, HT - 1);
    check("act_h19", act_v3[19], 0);
    check("act_h20", act_v3[20], 1);
    check("act_h79", act_v3[79], 1);
    check("act_h80", act_v3[80], 0);
    check("act_v2", act_v2, 0);
    check("act_v8", act_v8, 1);
    check("act_v9", act_v9, 0);
    run_line(HT, 1);
    run_line(HT, 1);
    check("frame_ok_locked", locked, 1);
    check("frame_ok_no_err", err_cnt, 0);
    run_line(HT - 1, 0);
    run_line(HT, 0);
    check("short_line_err", f_err, 1);
    check("short_line_unlock", f_lk, 0);
    run_line(HT, 0);
    run_line(HT, 0);
    run_line(HT, 0);
    check("relock_not_yet", f_lk, 0);
    run_line(HT, 0);
    check("relock_4_lines", f_lk, 1);
    check("short_line_err_cnt", err_cnt, 1);
    for (int l = 8; l < VT; l++) run_line(HT, 0);
    run_frame(VT - 1);
    run_line(HT, 1);
    check("short_frame_err", f_err, 1);
    check("short_frame_unlock", f_lk, 0);
    check("short_frame_fs", f_fs, 1);
    check("short_frame_vpos", f_vp, 0);
    check("short_frame_ls", f_ls, 1);
    for (int l = 1; l < 6; l++) run_line(HT, l < 2);
    check("short_frame_err_cnt", err_cnt, 2);
    check("relock_before_hold", locked, 1);
    step(1'b1, 1'b1);
    check("hold_h_pos_total", h_pos, HT);
    check("hold_still_locked", locked, 1);
    step(1'b1, 1'b1);
    check("timeout_err", sync_err, 1);
    check("timeout_unlock", locked, 0);
    step(1'b1, 1'b1);
    check("timeout_err_1cyc", sync_err, 0);
    for (int i = 0; i < 930; i++) step(1'b1, 1'b1);
    check("h_pos_saturate", h_pos, 1023);
    check("timeout_err_cnt", err_cnt, 3);
    for (int l = 0; l < 6; l++) run_line(HT, 0);
    check("relock_after_sat", locked, 1);
    run_line(30, 0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
    check("mid_rst_h_pos", h_pos, 0);
    check("mid_rst_v_pos", v_pos, 0);
    check("mid_rst_locked", locked, 0);
    check("mid_rst_active", active, 0);
    check("mid_rst_ls", line_start, 0);
    check("mid_rst_fs", frame_start, 0);
    check("mid_rst_err", sync_err, 0);
    reset = 1'b1;
    step(1'b1, 1'b1);
    check("post_rst_h_pos", h_pos, 1);
    check("post_rst_locked", locked, 0);
    check("err_pulse_width", long_err, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
